// File: rtl/onehot_stream_encoder_if.sv
// Stream bundle for onehot_stream_encoder: the vector input handshake and the
// index output handshake, grouped so the encoder and its users share one port.
interface onehot_stream_encoder_if #(
  parameter int unsigned N_OUT = 4,
  parameter int unsigned N_IN  = 16
);
  logic [N_IN-1:0]  IN_DATA;
  logic             IN_VALID;
  logic             IN_READY;
  logic [N_OUT-1:0] OUT_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             OUT_LAST;
  logic             OUT_ZERO;

  // Producer of vectors and consumer of index beats
  modport master (
    output IN_DATA, IN_VALID, OUT_READY,
    input  IN_READY, OUT_DATA, OUT_VALID, OUT_LAST, OUT_ZERO
  );

  // The encoder itself
  modport slave (
    input  IN_DATA, IN_VALID, OUT_READY,
    output IN_READY, OUT_DATA, OUT_VALID, OUT_LAST, OUT_ZERO
  );
endinterface

// File: rtl/onehot_stream_encoder.sv
// One-hot / bit-vector stream encoder: accepts an N_IN-bit vector and emits
// the index of every set bit, lowest first, one beat per cycle, flagging the
// final beat. An all-zero vector yields a single beat with OUT_ZERO set.
module onehot_stream_encoder #(
  parameter int unsigned N_OUT = 4,
  parameter int unsigned N_IN  = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  onehot_stream_encoder_if.slave   stream
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t           state, state_n;
  logic [N_IN-1:0]  mask, mask_n;
  logic             zflag, zflag_n;

  logic [N_IN-1:0]  mask_low_cleared;
  logic [N_OUT-1:0] low_idx;
  logic             single;
  logic             last;
  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             beat;

  // Priority encode of the registered mask; lowest set bit wins, 0 when empty
  always_comb begin
    low_idx = '0;
    for (int unsigned i = N_IN; i > 0; i--) begin
      if (mask[i-1]) low_idx = N_OUT'(i - 1);
    end
  end

  // Final-beat detection and handshake qualifiers
  always_comb begin
    mask_low_cleared = mask & (mask - N_IN'(1));
    single    = (mask != '0) && (mask_low_cleared == '0);
    last      = (state == EMIT) && (zflag || single);
    out_valid = (state == EMIT);
    // Ready also on the final beat's handshake so back-to-back vectors see no bubble
    in_ready  = (state == IDLE) || (last && stream.OUT_READY);
    accept    = stream.IN_VALID && in_ready;
    beat      = out_valid && stream.OUT_READY;
  end

  // Output drive; everything forced to zero outside EMIT
  always_comb begin
    stream.IN_READY  = in_ready;
    stream.OUT_VALID = out_valid;
    stream.OUT_DATA  = '0;
    stream.OUT_LAST  = 1'b0;
    stream.OUT_ZERO  = 1'b0;
    if (state == EMIT) begin
      stream.OUT_DATA = low_idx;
      stream.OUT_LAST = last;
      stream.OUT_ZERO = zflag;
    end
  end

  // Next-state: a new accept takes precedence over retiring the final beat
  always_comb begin
    state_n = state;
    mask_n  = mask;
    zflag_n = zflag;
    if (accept) begin
      state_n = EMIT;
      mask_n  = stream.IN_DATA;
      zflag_n = (stream.IN_DATA == '0);
    end else if (beat) begin
      if (last) begin
        state_n = IDLE;
        mask_n  = '0;
        zflag_n = 1'b0;
      end else begin
        mask_n  = mask_low_cleared;
      end
    end
  end

  // State, pending mask and zero flag registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      mask  <= '0;
      zflag <= 1'b0;
    end else begin
      state <= state_n;
      mask  <= mask_n;
      zflag <= zflag_n;
    end
  end

endmodule

// File: doc/onehot_stream_encoder.md
Name: onehot_stream_encoder

Overview:
- Encoder counterpart to the 4-to-16 decoder. It accepts a 16-bit bit-vector through a valid/ready handshake.
- It emits the 4-bit index of every set bit, one index per beat, lowest index first, and flags the final beat.
- A single-hot input produces exactly one beat, so the output can drive the decoder's 4-bit input directly and regenerate the one-hot word.

Parameters:
- N_OUT, 4, index width in bits.
- N_IN, 16, input vector width. Must equal 2**N_OUT.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- IN_DATA  input  N_IN  bit-vector to encode.
- IN_VALID  input  1  IN_DATA is valid.
- IN_READY  output  1  block can accept a vector this cycle.
- OUT_DATA  output  N_OUT  index of the current set bit.
- OUT_VALID  output  1  OUT_DATA, OUT_LAST and OUT_ZERO are valid.
- OUT_READY  input  1  downstream accepts the current beat.
- OUT_LAST  output  1  current beat is the final beat for this vector.
- OUT_ZERO  output  1  accepted vector was all zeros; OUT_DATA is 0.

Behaviour:
- Internal state:
  - N_IN-bit pending mask register `mask`.
  - 1-bit zero flag register `zflag`.
  - FSM with two states, IDLE and EMIT.
- Reset (async assert, release synchronous to CLK): state=IDLE, mask=0, zflag=0, OUT_VALID=0, OUT_LAST=0, OUT_ZERO=0, OUT_DATA=0, IN_READY=1.
- Accept: occurs on a rising edge where IN_VALID && IN_READY.
  - mask <= IN_DATA
  - zflag <= (IN_DATA == 0)
  - state <= EMIT
- IN_READY = (state==IDLE) || (state==EMIT && OUT_READY && OUT_LAST). This is combinational and lets a new vector be accepted on the same edge as the final beat's handshake, with no bubble.
- In EMIT:
  - OUT_VALID=1.
  - OUT_DATA = index of the lowest set bit of mask. This is a combinational priority encode of the registered mask; it does not look at IN_DATA.
  - OUT_LAST = 1 when mask has exactly one bit set, or when zflag=1.
  - OUT_ZERO = zflag.
  - OUT_DATA=0 whenever mask==0.
- In IDLE: OUT_VALID=0, OUT_LAST=0, OUT_ZERO=0, OUT_DATA=0.
- Beat handshake: occurs on an edge where OUT_VALID && OUT_READY.
  - Non-final beat: clear the lowest set bit of mask (mask <= mask & (mask-1)) and stay in EMIT.
  - Final beat, no new accept on the same edge: state <= IDLE, mask <= 0, zflag <= 0.
  - Final beat with IN_VALID=1 on the same edge: the accept rule wins; the new vector is loaded and state stays EMIT.
- Backpressure: while OUT_READY=0 the beat holds stable. OUT_DATA, OUT_LAST, OUT_ZERO and mask do not change.
- Latency: first beat is visible in the cycle after the accept edge. Sustained throughput is 1 beat/cycle. A vector with k set bits occupies max(k,1) beats.
- Zero vector: produces exactly one beat with OUT_DATA=0, OUT_ZERO=1, OUT_LAST=1.
- Full vector (16'hFFFF): produces 16 beats with indices 0..15; OUT_LAST is set only on index 15.
- IN_DATA is sampled only at the accept edge. Later changes to IN_DATA have no effect on the beats of the vector already accepted.
- RST asserted mid-vector: the remaining beats are discarded, outputs return to reset values immediately, and there is no residual output after release.

Test Plan:
- Decoder round-trip:
  - Stimulus: IN_DATA=16'h0001, 16'h0002, ... 16'h8000, one vector at a time, OUT_READY=1.
  - Required: each vector gives one beat, OUT_DATA = 0..15 respectively, OUT_LAST=1, OUT_ZERO=0. Feeding OUT_DATA into the 4-to-16 decoder reproduces the input word.
- Multi-bit vector:
  - Stimulus: IN_DATA=16'h8421, OUT_READY=1.
  - Required: beats OUT_DATA=0, 5, 10, 15 on consecutive cycles. OUT_LAST=1 only on the beat with OUT_DATA=15. IN_READY=1 only during that final cycle.
- Zero vector and back-to-back accept:
  - Stimulus: IN_DATA=16'h0000, then 16'h0300 held valid with OUT_READY=1.
  - Required: one beat OUT_DATA=0, OUT_ZERO=1, OUT_LAST=1. The second vector is accepted on that beat's edge; the next cycles give beats 8 and 9 with no idle cycle between.
- Backpressure:
  - Stimulus: IN_DATA=16'hFFFF; OUT_READY toggles 1,0,0,1,...
  - Required: 16 beats with OUT_DATA 0..15 in order, none lost or duplicated. Outputs stay stable while OUT_READY=0. OUT_LAST=1 only with OUT_DATA=15.
- Input isolation:
  - Stimulus: accept 16'h0011, then change IN_DATA to 16'hFFFF with IN_VALID=1 while in EMIT (IN_READY=0).
  - Required: beats 0 then 4. 16'hFFFF is accepted only on the edge of beat 4's handshake.
- Reset mid-operation:
  - Stimulus: accept 16'h00F0, take the beat with OUT_DATA=4, then pulse RST asynchronously between clock edges.
  - Required: OUT_VALID goes to 0 before the next edge and IN_READY=1. No beats 5, 6 or 7 appear after release.
